// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data, routing read responses to their owner
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  input  logic                    if_flush,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  logic [READ_LATENCY-1:0] vld, own, own_next;
  logic fetch_pri;
  assign fetch_pri = wait_cnt == CW'(MAX_WAIT);
  assign own_next = READ_LATENCY'({own, d_gnt});
  assign if_rvalid = !rst && vld[READ_LATENCY-1] && !own[READ_LATENCY-1] && !if_flush;
  assign d_rvalid = !rst && vld[READ_LATENCY-1] && own[READ_LATENCY-1];
  assign if_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  // data wins unless fetch has starved for MAX_WAIT cycles; all outputs idle during reset
  always_comb begin
    if_gnt = !rst && if_req && (!d_req || fetch_pri);
    d_gnt = !rst && d_req && !(if_req && fetch_pri);
    mem_req = if_gnt || d_gnt;
    mem_we = d_gnt && d_we;
    mem_addr = d_gnt ? d_addr : if_gnt ? (if_addr & ~ADDR_WIDTH'(3)) : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    mem_be = d_gnt ? d_be : if_gnt ? '1 : '0;
  end
  // starvation counter and {valid, owner} response pipe; flush kills fetch entries incl. the one entering now
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      vld <= '0;
      own <= '0;
    end else begin
      wait_cnt <= (!if_req || if_gnt) ? '0 : fetch_pri ? wait_cnt : wait_cnt + CW'(1);
      vld <= READ_LATENCY'({vld, mem_req && !mem_we}) & (own_next | {READ_LATENCY{!if_flush}});
      own <= own_next;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus scoreboard over three read latencies sharing one stimulus
module tb_mem_port_arbiter;
  typedef struct {
    bit r, ir;
    bit [11:0] ia;
    bit fl, dr, dw;
    bit [11:0] da;
    bit [31:0] wd;
    bit [3:0] be;
    bit eig, edg;
  } vec_t;
  typedef struct {
    int due;
    int inst;
    bit own;
    bit [31:0] data;
  } exp_t;
  logic clk = 0, rst = 1, if_req = 0, if_flush = 0, d_req = 0, d_we = 0;
  logic [11:0] if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0] d_be = '0;
  logic if_gnt_o [3], d_gnt_o [3], if_rvalid_o [3], d_rvalid_o [3], mem_req_o [3], mem_we_o [3];
  logic [31:0] if_rdata_o [3], d_rdata_o [3], mem_wdata_o [3], mem_rdata_i [3];
  logic [11:0] mem_addr_o [3];
  logic [3:0] mem_be_o [3];
  bit [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [9:0] wa;
  logic [31:0] iw, wm;
  exp_t sb[$];
  vec_t tv[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction
  // memory stores the difference from init_word so it needs no initialisation
  assign wa = mem_addr_o[0][11:2];
  assign iw = init_word(wa);
  assign wm = {{8{mem_be_o[0][3]}}, {8{mem_be_o[0][2]}}, {8{mem_be_o[0][1]}}, {8{mem_be_o[0][0]}}};
  always @(posedge clk)
    if (mem_req_o[0] && mem_we_o[0])
      mem[wa] <= (((mem[wa] ^ iw) & ~wm) | (mem_wdata_o[0] & wm)) ^ iw;
  for (genvar g = 0; g < 3; g++) begin : gi
    logic [31:0] pipe [g+1];
    logic [9:0] ra;
    assign ra = mem_addr_o[g][11:2];
    assign mem_rdata_i[g] = pipe[g];
    always @(posedge clk) begin
      pipe[0] <= mem[ra] ^ init_word(ra);
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    mem_port_arbiter #(.READ_LATENCY(g + 1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[g]), .if_flush(if_flush),
      .if_rvalid(if_rvalid_o[g]), .if_rdata(if_rdata_o[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt_o[g]), .d_rvalid(d_rvalid_o[g]), .d_rdata(d_rdata_o[g]),
      .mem_req(mem_req_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_be(mem_be_o[g]), .mem_rdata(mem_rdata_i[g])
    );
  end
  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h exp=%h", nm, inst + 1, cyc, got, exp);
    end
  endtask
  function automatic vec_t mk(input bit r, input bit ir, input bit [11:0] ia, input bit fl, input bit dr,
                              input bit dw, input bit [11:0] da, input bit [31:0] wd, input bit [3:0] be,
                              input bit eig, input bit edg);
    vec_t t;
    t.r = r; t.ir = ir; t.ia = ia; t.fl = fl; t.dr = dr; t.dw = dw;
    t.da = da; t.wd = wd; t.be = be; t.eig = eig; t.edg = edg;
    return t;
  endfunction
  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic step(input vec_t v);
    bit ev_i, ev_d;
    bit [31:0] ed;
    @(negedge clk);
    rst = v.r; if_req = v.ir; if_addr = v.ia; if_flush = v.fl;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.wd; d_be = v.be;
    #1;
    chk("if_gnt", 0, 32'(if_gnt_o[0]), 32'(v.eig));
    chk("d_gnt", 0, 32'(d_gnt_o[0]), 32'(v.edg));
    chk("mem_req", 0, 32'(mem_req_o[0]), 32'(v.eig | v.edg));
    if (v.eig) begin
      chk("if_mem_addr", 0, 32'(mem_addr_o[0]), 32'({v.ia[11:2], 2'b00}));
      chk("if_mem_we", 0, 32'(mem_we_o[0]), 32'd0);
      chk("if_mem_be", 0, 32'(mem_be_o[0]), 32'hF);
    end
    if (v.edg) begin
      chk("d_mem_addr", 0, 32'(mem_addr_o[0]), 32'(v.da));
      chk("d_mem_we", 0, 32'(mem_we_o[0]), 32'(v.dw));
      chk("d_mem_be", 0, 32'(mem_be_o[0]), 32'(v.be));
      if (v.dw) chk("d_mem_wdata", 0, mem_wdata_o[0], v.wd);
    end
    if (v.r) begin
      chk("rst_mem_addr", 0, 32'(mem_addr_o[0]), 32'd0);
      chk("rst_mem_wdata", 0, mem_wdata_o[0], 32'd0);
      chk("rst_mem_be", 0, 32'(mem_be_o[0]), 32'd0);
      chk("rst_mem_we", 0, 32'(mem_we_o[0]), 32'd0);
      sb.delete();
    end
    if (v.fl) for (int i = sb.size() - 1; i >= 0; i--) if (!sb[i].own) sb.delete(i);
    for (int g = 0; g < 3; g++) begin
      ev_i = 0; ev_d = 0; ed = '0;
      foreach (sb[i]) if (sb[i].inst == g && sb[i].due == cyc) begin
        if (sb[i].own) ev_d = 1; else ev_i = 1;
        ed = sb[i].data;
      end
      chk("if_rvalid", g, 32'(if_rvalid_o[g]), 32'(ev_i));
      chk("d_rvalid", g, 32'(d_rvalid_o[g]), 32'(ev_d));
      if (ev_i) chk("if_rdata", g, if_rdata_o[g], ed);
      if (ev_d) chk("d_rdata", g, d_rdata_o[g], ed);
    end
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due <= cyc) sb.delete(i);
    if (v.eig && !v.fl) for (int g = 0; g < 3; g++) sb.push_back('{cyc + g + 1, g, 1'b0, ref_mem[v.ia[11:2]]});
    if (v.edg && !v.dw) for (int g = 0; g < 3; g++) sb.push_back('{cyc + g + 1, g, 1'b1, ref_mem[v.da[11:2]]});
    if (v.edg && v.dw) for (int b = 0; b < 4; b++) if (v.be[b]) ref_mem[v.da[11:2]][8*b +: 8] = v.wd[8*b +: 8];
    cyc++;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i[9:0]);
    tv.push_back(mk(1, 1, 12'h020, 0, 1, 0, 12'h030, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 12'h020, 0, 1, 0, 12'h030, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 12'h020, 0, 1, 0, 12'h030, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h020, 0, 1, 0, 12'h034, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h020, 0, 1, 0, 12'h038, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h020, 0, 1, 0, 12'h03C, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 12'h024, 0, 1, 0, 12'h03C, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h024, 0, 1, 0, 12'h040, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h024, 0, 1, 0, 12'h044, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h024, 0, 1, 0, 12'h048, 0, 0, 1, 0));
    tv.push_back(idle());
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h050, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h054, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 12'h060, 0, 1, 0, 12'h058, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h05C, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h064, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h068, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h060, 0, 1, 0, 12'h06C, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 12'h000, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 12'h004, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 12'h008, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 12'h00D, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(idle());
    tv.push_back(idle());
    tv.push_back(idle());
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 12'h010, 32'hDEADBEEF, 4'b0011, 0, 1));
    tv.push_back(mk(0, 1, 12'h070, 0, 1, 0, 12'h010, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 12'h070, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(idle());
    tv.push_back(idle());
    tv.push_back(idle());
    foreach (tv[i]) step(tv[i]);
    step(mk(0, 1, 12'h100, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 1, 12'h104, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 1, 12'h108, 1, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 12'h014, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) step(idle());
    step(mk(0, 1, 12'h120, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 12'h018, 0, 0, 0, 1));
    step(mk(0, 1, 12'h124, 1, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) step(idle());
    step(mk(0, 0, 0, 0, 1, 0, 12'h01C, 0, 0, 0, 1));
    step(mk(1, 1, 12'h200, 0, 1, 0, 12'h204, 0, 0, 0, 0));
    step(idle());
    step(idle());
    step(mk(0, 0, 0, 0, 1, 0, 12'h01C, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) step(idle());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
